fft_dit_stage_serial: RTL and testbench

Parametrised radix-2 decimation-in-time FFT stage for any power-of-two point count and any stage index. It replaces the fully parallel per-stage butterfly banks. A whole frame is accepted on a valid/ready handshake. One pipelined butterfly engine then processes the frame serially, one butterfly per cycle. The result frame is held on a valid/ready output handshake, so stages can be chained into a full FFT with configurable growth or scaling.

---
 rtl/fft_dit_stage_serial.sv | 202 ++++++++++++++++++++
 tb/tb_fft_dit_stage_serial.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_dit_stage_serial.sv
`default_nettype none
// ============================================================================
// Module  : fft_dit_stage_serial
// Brief   : Radix-2 DIT FFT stage. Accepts a whole frame, then runs one
//           pipelined butterfly per cycle and holds the result frame.
// Rev     : 1.0  initial release
// ============================================================================
module fft_dit_stage_serial #(
  parameter int p_points      = 32,
  parameter int p_stage       = 2,
  parameter int p_dataBits    = 16,
  parameter int p_twiddleBits = 16,
  parameter int p_twiddleFrac = 14,
  parameter int p_scale       = 0,
  parameter int p_outBits     = p_dataBits + 1 - p_scale
) (
  input  logic                                     CLK,
  input  logic                                     RST,
  input  logic                                     i_valid,
  output logic                                     o_in_ready,
  input  logic [p_points*2*p_dataBits-1:0]         i_data,
  input  logic [(p_points/2)*2*p_twiddleBits-1:0]  i_twiddle,
  output logic                                     o_valid,
  input  logic                                     i_ready,
  output logic [p_points*2*p_outBits-1:0]          o_data,
  output logic                                     o_busy
);

  localparam int c_dw     = p_dataBits;
  localparam int c_tw     = p_twiddleBits;
  localparam int c_ow     = p_outBits;
  localparam int c_half_n = p_points / 2;
  localparam int c_span   = 1 << p_stage;
  localparam int c_iw     = $clog2(p_points);
  localparam int c_kw     = $clog2(p_points / 2);
  localparam int c_pw     = c_dw + c_tw + 1;
  localparam int c_p      = c_dw + 2;
  localparam int c_s      = c_dw + 3;

  localparam logic [c_kw-1:0]          c_last = c_kw'(c_half_n - 1);
  localparam logic signed [c_pw-1:0]   c_rnd  = c_pw'(2 ** (p_twiddleFrac - 1));
  localparam logic signed [c_s-1:0]    c_one  = c_s'(1);
  localparam logic signed [c_s-1:0]    c_max  = c_s'((2 ** (c_ow - 1)) - 1);
  localparam logic signed [c_s-1:0]    c_min  = c_s'(-(2 ** (c_ow - 1)));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;
  logic   w_accept, w_issue;

  logic [2*c_dw-1:0] r_in  [p_points];
  logic [2*c_tw-1:0] r_tw  [c_half_n];
  logic [2*c_ow-1:0] r_out [p_points];
  logic [c_kw-1:0]   r_cnt;

  logic                    r_v1;
  logic [c_iw-1:0]         r_top1, r_bot1;
  logic [2*c_dw-1:0]       r_a1;
  logic signed [c_p-1:0]   r_pr, r_pi;

  logic [c_iw-1:0]         w_k, w_top, w_bot;
  logic [c_kw-1:0]         w_pos;
  logic [2*c_dw-1:0]       w_a, w_b;
  logic [2*c_tw-1:0]       w_w;
  logic signed [c_pw-1:0]  w_br, w_bi, w_wr, w_wi, w_pr_full, w_pi_full;
  logic signed [c_s-1:0]   w_ar, w_ai, w_prx, w_pix;
  logic signed [c_s-1:0]   w_sum_r, w_sum_i, w_dif_r, w_dif_i;

  // ---------------------------------------------------------------- control
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_issue = 1'b1;
        if (r_cnt == c_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!r_v1) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (i_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_in_ready = (r_state == S_IDLE);
  assign o_valid    = (r_state == S_DONE);
  assign o_busy     = (r_state == S_RUN) || (r_state == S_DRAIN);

  // ------------------------------------------------------- frame capture
  // Every twiddle word is captured; only indices below the span are ever read.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < p_points; k++) r_in[k] <= '0;
      for (int j = 0; j < c_half_n; j++) r_tw[j] <= '0;
      r_cnt <= '0;
    end else begin
      if (w_accept) begin
        for (int k = 0; k < p_points; k++) r_in[k] <= i_data[k*2*c_dw +: 2*c_dw];
        for (int j = 0; j < c_half_n; j++) r_tw[j] <= i_twiddle[j*2*c_tw +: 2*c_tw];
        r_cnt <= '0;
      end else if (w_issue) begin
        r_cnt <= r_cnt + c_kw'(1);
      end
    end
  end

  // ------------------------------------------------- butterfly addressing
  // top = (k >> s) * 2*span + (k mod span); bot sits one span above it.
  assign w_k   = c_iw'(r_cnt);
  assign w_top = ((w_k >> p_stage) << (p_stage + 1)) | (w_k & c_iw'(c_span - 1));
  assign w_bot = w_top + c_iw'(c_span);
  assign w_pos = r_cnt & c_kw'(c_span - 1);

  assign w_a = r_in[w_top];
  assign w_b = r_in[w_bot];
  assign w_w = r_tw[w_pos];

  // ------------------------------------------- stage 1: complex multiply
  assign w_br = {{(c_pw-c_dw){w_b[2*c_dw-1]}}, w_b[2*c_dw-1:c_dw]};
  assign w_bi = {{(c_pw-c_dw){w_b[c_dw-1]}},   w_b[c_dw-1:0]};
  assign w_wr = {{(c_pw-c_tw){w_w[2*c_tw-1]}}, w_w[2*c_tw-1:c_tw]};
  assign w_wi = {{(c_pw-c_tw){w_w[c_tw-1]}},   w_w[c_tw-1:0]};

  assign w_pr_full = w_br * w_wr - w_bi * w_wi + c_rnd;
  assign w_pi_full = w_br * w_wi + w_bi * w_wr + c_rnd;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_v1   <= 1'b0;
      r_top1 <= '0;
      r_bot1 <= '0;
      r_a1   <= '0;
      r_pr   <= '0;
      r_pi   <= '0;
    end else begin
      r_v1 <= w_issue;
      if (w_issue) begin
        r_top1 <= w_top;
        r_bot1 <= w_bot;
        r_a1   <= w_a;
        r_pr   <= c_p'(w_pr_full >>> p_twiddleFrac);
        r_pi   <= c_p'(w_pi_full >>> p_twiddleFrac);
      end
    end
  end

  // --------------------------------------------- stage 2: add / subtract
  assign w_ar  = {{(c_s-c_dw){r_a1[2*c_dw-1]}}, r_a1[2*c_dw-1:c_dw]};
  assign w_ai  = {{(c_s-c_dw){r_a1[c_dw-1]}},   r_a1[c_dw-1:0]};
  assign w_prx = {r_pr[c_p-1], r_pr};
  assign w_pix = {r_pi[c_p-1], r_pi};

  assign w_sum_r = w_ar + w_prx;
  assign w_sum_i = w_ai + w_pix;
  assign w_dif_r = w_ar - w_prx;
  assign w_dif_i = w_ai - w_pix;

  function automatic logic [c_ow-1:0] fn_out(input logic signed [c_s-1:0] v);
    logic signed [c_s-1:0] sv;
    sv = (p_scale != 0) ? ((v + c_one) >>> 1) : v;
    if (sv > c_max)      sv = c_max;
    else if (sv < c_min) sv = c_min;
    return c_ow'(sv);
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < p_points; k++) r_out[k] <= '0;
    end else if (r_v1) begin
      r_out[r_top1] <= {fn_out(w_sum_r), fn_out(w_sum_i)};
      r_out[r_bot1] <= {fn_out(w_dif_r), fn_out(w_dif_i)};
    end
  end

  generate
    for (genvar g = 0; g < p_points; g++) begin : g_pack
      assign o_data[g*2*c_ow +: 2*c_ow] = r_out[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fft_dit_stage_serial.sv
`default_nettype none
// Testbench for fft_dit_stage_serial: directed and random frames against a
// group/position reference model of the radix-2 butterfly stage.
module tb_fft_dit_stage_serial;

  localparam int N   = 32;
  localparam int DW  = 16;
  localparam int TW  = 16;
  localparam int F   = 14;
  localparam int OW0 = 17;
  localparam int OW1 = 16;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] ivld, irdy;
  logic ov0, ov1, ov2, rd0, rd1, rd2, busy0, busy1, busy2;
  logic [N*2*DW-1:0]     i_data;
  logic [(N/2)*2*TW-1:0] i_twiddle;
  logic [N*2*OW0-1:0]    odata0, odata2;
  logic [N*2*OW1-1:0]    odata1;

  int in_re[N], in_im[N], tw_re[N/2], tw_im[N/2];
  int exp_re[N], exp_im[N], act_re[N], act_im[N];
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fft_dit_stage_serial #(.p_points(N), .p_stage(2), .p_dataBits(DW), .p_twiddleBits(TW),
                         .p_twiddleFrac(F), .p_scale(0)) dut (
    .CLK(clk), .RST(rst), .i_valid(ivld[0]), .o_in_ready(rd0), .i_data(i_data),
    .i_twiddle(i_twiddle), .o_valid(ov0), .i_ready(irdy[0]), .o_data(odata0), .o_busy(busy0));

  fft_dit_stage_serial #(.p_points(N), .p_stage(2), .p_dataBits(DW), .p_twiddleBits(TW),
                         .p_twiddleFrac(F), .p_scale(1)) dut_sc (
    .CLK(clk), .RST(rst), .i_valid(ivld[1]), .o_in_ready(rd1), .i_data(i_data),
    .i_twiddle(i_twiddle), .o_valid(ov1), .i_ready(irdy[1]), .o_data(odata1), .o_busy(busy1));

  fft_dit_stage_serial #(.p_points(N), .p_stage(0), .p_dataBits(DW), .p_twiddleBits(TW),
                         .p_twiddleFrac(F), .p_scale(0)) dut_s0 (
    .CLK(clk), .RST(rst), .i_valid(ivld[2]), .o_in_ready(rd2), .i_data(i_data),
    .i_twiddle(i_twiddle), .o_valid(ov2), .i_ready(irdy[2]), .o_data(odata2), .o_busy(busy2));

  function automatic logic f_ovld(int d);
    case (d) 0: return ov0; 1: return ov1; default: return ov2; endcase
  endfunction

  function automatic logic f_rdy(int d);
    case (d) 0: return rd0; 1: return rd1; default: return rd2; endcase
  endfunction

  // Reference: walk groups of 2*span points, butterfly (p, p+span) with W[p].
  task automatic model(input int s, input int sc, input int ow);
    int span, t, b, hi, lo;
    longint pr, pi, v[4];
    span = 1 << s;
    hi = (1 << (ow - 1)) - 1;
    lo = -(1 << (ow - 1));
    for (int g = 0; g < N; g += 2 * span) begin
      for (int p = 0; p < span; p++) begin
        t = g + p;
        b = t + span;
        pr = longint'(in_re[b]) * tw_re[p] - longint'(in_im[b]) * tw_im[p];
        pi = longint'(in_re[b]) * tw_im[p] + longint'(in_im[b]) * tw_re[p];
        pr = (pr + (1 << (F - 1))) >>> F;
        pi = (pi + (1 << (F - 1))) >>> F;
        v[0] = in_re[t] + pr; v[1] = in_im[t] + pi;
        v[2] = in_re[t] - pr; v[3] = in_im[t] - pi;
        for (int i = 0; i < 4; i++) begin
          if (sc != 0) v[i] = (v[i] + 1) >>> 1;
          if (v[i] > hi) v[i] = hi;
          if (v[i] < lo) v[i] = lo;
        end
        exp_re[t] = int'(v[0]); exp_im[t] = int'(v[1]);
        exp_re[b] = int'(v[2]); exp_im[b] = int'(v[3]);
      end
    end
  endtask

  task automatic rand_frame();
    for (int k = 0; k < N; k++) begin
      in_re[k] = int'($urandom_range(65535)) - 32768;
      in_im[k] = int'($urandom_range(65535)) - 32768;
    end
    for (int j = 0; j < N/2; j++) begin
      tw_re[j] = int'($urandom_range(32768)) - 16384;
      tw_im[j] = int'($urandom_range(32768)) - 16384;
    end
  endtask

  task automatic drive_bus();
    for (int k = 0; k < N; k++) begin
      i_data[k*2*DW + DW +: DW] = DW'(in_re[k]);
      i_data[k*2*DW +: DW]      = DW'(in_im[k]);
    end
    for (int j = 0; j < N/2; j++) begin
      i_twiddle[j*2*TW + TW +: TW] = TW'(tw_re[j]);
      i_twiddle[j*2*TW +: TW]      = TW'(tw_im[j]);
    end
  endtask

  task automatic get_actual(input int d);
    logic signed [OW0-1:0] r17, i17;
    logic signed [OW1-1:0] r16, i16;
    for (int k = 0; k < N; k++) begin
      if (d == 1) begin
        r16 = odata1[k*2*OW1 + OW1 +: OW1];
        i16 = odata1[k*2*OW1 +: OW1];
        act_re[k] = int'(r16); act_im[k] = int'(i16);
      end else begin
        r17 = (d == 0) ? odata0[k*2*OW0 + OW0 +: OW0] : odata2[k*2*OW0 + OW0 +: OW0];
        i17 = (d == 0) ? odata0[k*2*OW0 +: OW0] : odata2[k*2*OW0 +: OW0];
        act_re[k] = int'(r17); act_im[k] = int'(i17);
      end
    end
  endtask

  // Present the frame, wait for acceptance, then count edges until o_valid.
  task automatic run_frame(input int d, output int lat, output bit tmo);
    int n;
    drive_bus();
    ivld[d] = 1'b1;
    n = 0;
    while (!f_rdy(d) && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    ivld[d] = 1'b0;
    lat = 0;
    while (!f_ovld(d) && lat < 200) begin @(posedge clk); #1; lat++; end
    tmo = !f_ovld(d);
  endtask

  task automatic release_out(input int d);
    irdy[d] = 1'b1;
    @(posedge clk); #1;
    irdy[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ivld = 3'b111; irdy = 3'b000;
    i_data = '0; i_twiddle = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ov0 !== 1'b0) $display("FAIL reset_valid: got %b want 0", ov0); else passed++;
    checks++; if (rd0 !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", rd0); else passed++;
    checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy0); else passed++;
    checks++; if (odata0 !== '0) $display("FAIL reset_data: got %h want 0", odata0); else passed++;
    ivld = 3'b000;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unity();
    int lat; bit tmo;
    for (int k = 0; k < N; k++) begin in_re[k] = k; in_im[k] = -k; end
    for (int j = 0; j < N/2; j++) begin tw_re[j] = 16384; tw_im[j] = 0; end
    model(2, 0, OW0);
    run_frame(0, lat, tmo);
    checks++; if (tmo || lat != 18) $display("FAIL unity_latency: got %0d (timeout %0d) want 18", lat, tmo); else passed++;
    get_actual(0);
    checks++; if (act_re[0] != 4 || act_im[0] != -4) $display("FAIL unity_out0: got (%0d,%0d) want (4,-4)", act_re[0], act_im[0]); else passed++;
    checks++; if (act_re[4] != -4 || act_im[4] != 4) $display("FAIL unity_out4: got (%0d,%0d) want (-4,4)", act_re[4], act_im[4]); else passed++;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (act_re[k] != exp_re[k] || act_im[k] != exp_im[k])
        $display("FAIL unity_frame[%0d]: got (%0d,%0d) want (%0d,%0d)", k, act_re[k], act_im[k], exp_re[k], exp_im[k]);
      else passed++;
    end
    release_out(0);
    checks++; if (ov0 !== 1'b0 || rd0 !== 1'b1) $display("FAIL unity_release: valid %b ready %b want 0/1", ov0, rd0); else passed++;
  endtask

  task automatic test_rotation();
    int lat; bit tmo;
    rand_frame();
    in_re[0] = 100; in_im[0] = 50; in_re[4] = 20; in_im[4] = -10;
    tw_re[0] = 0; tw_im[0] = -16384;
    model(2, 0, OW0);
    run_frame(0, lat, tmo);
    get_actual(0);
    checks++; if (tmo || act_re[0] != 90 || act_im[0] != 30) $display("FAIL rot_out0: got (%0d,%0d) want (90,30)", act_re[0], act_im[0]); else passed++;
    checks++; if (act_re[4] != 110 || act_im[4] != 70) $display("FAIL rot_out4: got (%0d,%0d) want (110,70)", act_re[4], act_im[4]); else passed++;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (act_re[k] != exp_re[k] || act_im[k] != exp_im[k])
        $display("FAIL rot_frame[%0d]: got (%0d,%0d) want (%0d,%0d)", k, act_re[k], act_im[k], exp_re[k], exp_im[k]);
      else passed++;
    end
    release_out(0);
  endtask

  task automatic test_saturation();
    int lat; bit tmo;
    rand_frame();
    in_re[0] = -32768; in_im[0] = 0; in_re[4] = -32768; in_im[4] = -32768;
    tw_re[0] = 11585; tw_im[0] = -11585;
    model(2, 0, OW0);
    run_frame(0, lat, tmo);
    get_actual(0);
    checks++; if (tmo || act_re[0] != -65536 || act_im[0] != 0) $display("FAIL sat_out0: got (%0d,%0d) want (-65536,0)", act_re[0], act_im[0]); else passed++;
    checks++; if (act_re[4] != 13572 || act_im[4] != 0) $display("FAIL sat_out4: got (%0d,%0d) want (13572,0)", act_re[4], act_im[4]); else passed++;
    for (int k = 0; k < N; k++) begin
      checks++;
      if (act_re[k] != exp_re[k] || act_im[k] != exp_im[k])
        $display("FAIL sat_frame[%0d]: got (%0d,%0d) want (%0d,%0d)", k, act_re[k], act_im[k], exp_re[k], exp_im[k]);
      else passed++;
    end
    release_out(0);
  endtask

  task automatic test_scale();
    int lat; bit tmo;
    for (int r = 0; r < 2; r++) begin
      rand_frame();
      if (r == 0) begin
        in_re[0] = 3; in_im[0] = 0; in_re[4] = 0; in_im[4] = 0;
        tw_re[0] = 16384; tw_im[0] = 0;
      end
      model(2, 1, OW1);
      run_frame(1, lat, tmo);
      checks++; if (tmo || lat != 18) $display("FAIL scale_latency: got %0d want 18", lat); else passed++;
      get_actual(1);
      if (r == 0) begin
        checks++;
        if (act_re[0] != 2 || act_im[0] != 0 || act_re[4] != 2 || act_im[4] != 0)
          $display("FAIL scale_round: got out0 (%0d,%0d) out4 (%0d,%0d) want (2,0) (2,0)", act_re[0], act_im[0], act_re[4], act_im[4]);
        else passed++;
      end
      for (int k = 0; k < N; k++) begin
        checks++;
        if (act_re[k] != exp_re[k] || act_im[k] != exp_im[k])
          $display("FAIL scale_frame%0d[%0d]: got (%0d,%0d) want (%0d,%0d)", r, k, act_re[k], act_im[k], exp_re[k], exp_im[k]);
        else passed++;
      end
      release_out(1);
    end
  endtask

  task automatic test_random();
    int lat; bit tmo; int d;
    for (int r = 0; r < 7; r++) begin
      d = (r < 4) ? 0 : 2;
      rand_frame();
      model((d == 0) ? 2 : 0, 0, OW0);
      run_frame(d, lat, tmo);
      checks++; if (tmo || lat != 18) $display("FAIL rand_latency%0d: got %0d want 18", r, lat); else passed++;
      get_actual(d);
      for (int k = 0; k < N; k++) begin
        checks++;
        if (act_re[k] != exp_re[k] || act_im[k] != exp_im[k])
          $display("FAIL rand_frame%0d[%0d]: got (%0d,%0d) want (%0d,%0d)", r, k, act_re[k], act_im[k], exp_re[k], exp_im[k]);
        else passed++;
      end
      release_out(d);
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit tmo;
    rand_frame();
    model(2, 0, OW0);
    run_frame(0, lat, tmo);
    rand_frame();
    drive_bus();
    ivld[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++; if (ov0 !== 1'b1 || rd0 !== 1'b0) $display("FAIL bp_hold%0d: valid %b ready %b want 1/0", c, ov0, rd0); else passed++;
      get_actual(0);
      for (int k = 0; k < N; k++) begin
        checks++;
        if (act_re[k] != exp_re[k] || act_im[k] != exp_im[k])
          $display("FAIL bp_stable%0d[%0d]: got (%0d,%0d) want (%0d,%0d)", c, k, act_re[k], act_im[k], exp_re[k], exp_im[k]);
        else passed++;
      end
    end
    irdy[0] = 1'b1;
    @(posedge clk); #1;
    irdy[0] = 1'b0;
    checks++; if (ov0 !== 1'b0 || rd0 !== 1'b1) $display("FAIL bp_idle: valid %b ready %b want 0/1", ov0, rd0); else passed++;
    @(posedge clk); #1;
    ivld[0] = 1'b0;
    checks++; if (busy0 !== 1'b1 || rd0 !== 1'b0) $display("FAIL bp_accept: busy %b ready %b want 1/0", busy0, rd0); else passed++;
    model(2, 0, OW0);
    lat = 0;
    while (!ov0 && lat < 200) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 18) $display("FAIL bp_latency: got %0d want 18", lat); else passed++;
    get_actual(0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (act_re[k] != exp_re[k] || act_im[k] != exp_im[k])
        $display("FAIL bp_frame2[%0d]: got (%0d,%0d) want (%0d,%0d)", k, act_re[k], act_im[k], exp_re[k], exp_im[k]);
      else passed++;
    end
    release_out(0);
  endtask

  task automatic test_reset_midrun();
    int lat; bit tmo;
    rand_frame();
    drive_bus();
    ivld[0] = 1'b1;
    @(posedge clk); #1;
    ivld[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checks++; if (busy0 !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy0); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (ov0 !== 1'b0 || busy0 !== 1'b0) $display("FAIL mid_rst_flags: valid %b busy %b want 0/0", ov0, busy0); else passed++;
    checks++; if (rd0 !== 1'b1) $display("FAIL mid_rst_ready: got %b want 1", rd0); else passed++;
    checks++; if (odata0 !== '0) $display("FAIL mid_rst_data: got %h want 0", odata0); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    rand_frame();
    model(2, 0, OW0);
    run_frame(0, lat, tmo);
    checks++; if (tmo || lat != 18) $display("FAIL mid_latency: got %0d want 18", lat); else passed++;
    get_actual(0);
    for (int k = 0; k < N; k++) begin
      checks++;
      if (act_re[k] != exp_re[k] || act_im[k] != exp_im[k])
        $display("FAIL mid_frame[%0d]: got (%0d,%0d) want (%0d,%0d)", k, act_re[k], act_im[k], exp_re[k], exp_im[k]);
      else passed++;
    end
    release_out(0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_unity();
    test_rotation();
    test_saturation();
    test_scale();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
